// File: rtl/dest_reg_scoreboard.sv
// dest_reg_scoreboard
// Purpose : tracks in-flight destination registers between decode and the
//           register-file write port; flags read-after-write hazards and
//           presents the retiring destination.
// Latency : stall is combinational (same cycle). An accepted write reaches
//           WB DEPTH-1 edges after its accept and leaves one edge later.
// Backpressure: stall tells decode to hold; a stalled issue is not accepted
//           and a bubble enters the pipe instead.
// Ports   : clk/rst (async active-high) ; issue_valid, issue_wr, issue_dest,
//           src_a, src_b, flush in ; stall, wb_valid, wb_dest, busy out.
// Option  : define SB_WB_BYPASS_EN to exclude the WB stage from the hazard
//           check (regfile writes first half-cycle, reads second half).
//           busy always covers every stage.
module dest_reg_scoreboard #(
   parameter int DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic        issue_wr,
   input  logic [4:0]  issue_dest,
   input  logic [4:0]  src_a,
   input  logic [4:0]  src_b,
   input  logic        flush,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_dest,
   output logic [31:0] busy
);

`ifdef SB_WB_BYPASS_EN
   localparam int NCHK = DEPTH - 1;
`else
   localparam int NCHK = DEPTH;
`endif

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [4:0]       dest_q [DEPTH];
   logic [4:0]       dest_d [DEPTH];
   logic             hit_a, hit_b;
   logic             accept;
   logic [31:0]      busy_c;

   // Hazard compare against the checked stages; r0 never matches.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int k = 0; k < NCHK; k++) begin
         if (valid_q[k] && (dest_q[k] == src_a)) hit_a = 1'b1;
         if (valid_q[k] && (dest_q[k] == src_b)) hit_b = 1'b1;
      end
      if (src_a == 5'd0) hit_a = 1'b0;
      if (src_b == 5'd0) hit_b = 1'b0;
   end

   assign stall  = issue_valid & (hit_a | hit_b);
   assign accept = issue_valid & ~stall & ~flush & issue_wr & (issue_dest != 5'd0);

   // Shift toward WB. On flush the shifted-in content is cleared, so the
   // whole pipe becomes empty while the current WB entry still retires
   // (it is already on wb_valid/wb_dest this cycle).
   always_comb begin
      valid_d[0] = accept;
      dest_d[0]  = accept ? issue_dest : 5'd0;
      for (int k = 1; k < DEPTH; k++) begin
         valid_d[k] = valid_q[k-1] & ~flush;
         dest_d[k]  = flush ? 5'd0 : dest_q[k-1];
      end
   end

   // Invalid entries always carry dest 0, so busy only needs the valid gate.
   always_comb begin
      busy_c = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_q[k]) busy_c[dest_q[k]] = 1'b1;
      end
      busy_c[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < DEPTH; k++) dest_q[k] <= 5'd0;
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < DEPTH; k++) dest_q[k] <= dest_d[k];
      end
   end

   assign busy     = busy_c;
   assign wb_valid = valid_q[DEPTH-1];
   assign wb_dest  = dest_q[DEPTH-1];

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
module tb_dest_reg_scoreboard;
   localparam int DEPTH = 3;
`ifdef SB_WB_BYPASS_EN
   localparam int NCHK = DEPTH - 1;
`else
   localparam int NCHK = DEPTH;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_wr, flush;
   logic [4:0]  issue_dest, src_a, src_b;
   logic        stall, wb_valid;
   logic [4:0]  wb_dest;
   logic [31:0] busy;

   int errors = 0;
   int checks = 0;

   dest_reg_scoreboard #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .stall(stall), .wb_valid(wb_valid), .wb_dest(wb_dest), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: list of in-flight writes, each with its age in edges
   // since acceptance. Age DEPTH-1 is the WB slot; age DEPTH has retired.
   typedef struct {
      logic [4:0] dest;
      int         age;
   } ent_t;
   ent_t inflight[$];

   function automatic logic [31:0] m_busy();
      logic [31:0] b = '0;
      foreach (inflight[i]) b = b | (32'd1 << inflight[i].dest);
      return b;
   endfunction

   function automatic logic m_hit(input logic [4:0] s);
      if (s == 5'd0) return 1'b0;
      foreach (inflight[i])
         if (inflight[i].dest == s && inflight[i].age < NCHK) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_stall();
      return issue_valid && (m_hit(src_a) || m_hit(src_b));
   endfunction

   function automatic logic m_wbv();
      foreach (inflight[i]) if (inflight[i].age == DEPTH-1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [4:0] m_wbd();
      foreach (inflight[i]) if (inflight[i].age == DEPTH-1) return inflight[i].dest;
      return 5'd0;
   endfunction

   // Apply inputs; returns at the falling edge where outputs are sampled.
   task automatic drive(input logic iv, input logic wr, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic fl);
      issue_valid = iv; issue_wr = wr; issue_dest = d;
      src_a = a; src_b = b; flush = fl;
      @(negedge clk);
   endtask

   // Clock edge plus model update.
   task automatic tick();
      logic       acc;
      logic [4:0] d;
      logic       fl;
      ent_t       nq[$];
      acc = issue_valid && !m_stall() && !flush && issue_wr && (issue_dest != 5'd0);
      d   = issue_dest;
      fl  = flush;
      @(posedge clk);
      foreach (inflight[i]) begin
         ent_t e = inflight[i];
         e.age = e.age + 1;
         if (e.age < DEPTH && !fl) nq.push_back(e);
      end
      if (acc) nq.push_back('{dest: d, age: 0});
      inflight = nq;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      inflight.delete();
      checks++;
      if (wb_valid !== 1'b0 || busy !== 32'd0) begin
         errors++;
         $display("FAIL reset_init: wb_valid=%b busy=%h expected 0/0", wb_valid, busy);
      end
      drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
      checks++;
      if (busy !== 32'h0000_000e || wb_valid !== 1'b1 || stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_prefill: busy=%h wb_valid=%b stall=%b expected 0000000e/1/1",
                  busy, wb_valid, stall);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (wb_valid !== 1'b0 || busy !== 32'd0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: wb_valid=%b busy=%h stall=%b expected 0/0/0",
                  wb_valid, busy, stall);
      end
      inflight.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue_valid = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         checks++;
         if (wb_valid !== 1'b0 || busy !== 32'd0) begin
            errors++;
            $display("FAIL reset_stale c%0d: wb_valid=%b busy=%h expected 0/0", c, wb_valid, busy);
         end
         tick();
      end
   endtask

   task automatic test_raw_r5();
      drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
      tick();
      for (int c = 1; c <= 4; c++) begin
         drive(1'b1, 1'b0, 5'd20, 5'd5, 5'd0, 1'b0);
         checks++;
         if (stall !== (c <= NCHK)) begin
            errors++;
            $display("FAIL raw_stall c%0d: stall=%b expected %b", c, stall, (c <= NCHK));
         end
         checks++;
         if (wb_valid !== (c == 3) || (c == 3 && wb_dest !== 5'd5)) begin
            errors++;
            $display("FAIL raw_wb c%0d: wb_valid=%b wb_dest=%0d expected %b/5",
                     c, wb_valid, wb_dest, (c == 3));
         end
         tick();
      end
   endtask

   task automatic test_r0_nowrite();
      drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0); tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
         checks++;
         if (busy !== 32'd0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL r0_nowrite c%0d: busy=%h wb_valid=%b stall=%b expected 0/0/0",
                     c, busy, wb_valid, stall);
         end
         tick();
      end
   endtask

   task automatic test_dup();
      drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
      tick();
      for (int c = 1; c <= 5; c++) begin
         if (c == 1) drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
         else        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         checks++;
         if (busy[7] !== (c <= 4)) begin
            errors++;
            $display("FAIL dup_busy c%0d: busy7=%b expected %b", c, busy[7], (c <= 4));
         end
         checks++;
         if (wb_valid !== (c == 3 || c == 4) || ((c == 3 || c == 4) && wb_dest !== 5'd7)) begin
            errors++;
            $display("FAIL dup_wb c%0d: wb_valid=%b wb_dest=%0d expected %b/7",
                     c, wb_valid, wb_dest, (c == 3 || c == 4));
         end
         tick();
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0); tick();
      drive(1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b1);
      checks++;
      if (wb_valid !== 1'b1 || wb_dest !== 5'd3 || busy !== 32'h0000_0058) begin
         errors++;
         $display("FAIL flush_wb3: wb_valid=%b wb_dest=%0d busy=%h expected 1/3/00000058",
                  wb_valid, wb_dest, busy);
      end
      tick();
      for (int c = 4; c <= 6; c++) begin
         drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         checks++;
         if (busy !== 32'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after c%0d: busy=%h wb_valid=%b expected 0/0", c, busy, wb_valid);
         end
         tick();
      end
   endtask

   task automatic test_stall_vs_issue();
      int last;
      last = NCHK + 1 + DEPTH + 1;
      drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
      tick();
      for (int c = 1; c <= last; c++) begin
         if (c <= NCHK + 1) drive(1'b1, 1'b1, 5'd12, 5'd3, 5'd0, 1'b0);
         else               drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         checks++;
         if (stall !== (c <= NCHK)) begin
            errors++;
            $display("FAIL siss_stall c%0d: stall=%b expected %b", c, stall, (c <= NCHK));
         end
         checks++;
         if (busy[12] !== (c >= NCHK + 2 && c <= NCHK + 1 + DEPTH)) begin
            errors++;
            $display("FAIL siss_busy12 c%0d: busy12=%b expected %b", c, busy[12],
                     (c >= NCHK + 2 && c <= NCHK + 1 + DEPTH));
         end
         checks++;
         if (wb_valid !== (c == DEPTH || c == NCHK + 1 + DEPTH) ||
             (c == DEPTH && wb_dest !== 5'd3) ||
             (c == NCHK + 1 + DEPTH && wb_dest !== 5'd12)) begin
            errors++;
            $display("FAIL siss_wb c%0d: wb_valid=%b wb_dest=%0d", c, wb_valid, wb_dest);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0));
         checks++;
         if (stall !== m_stall()) begin
            errors++;
            $display("FAIL rand_stall n%0d: stall=%b expected %b", n, stall, m_stall());
         end
         checks++;
         if (busy !== m_busy()) begin
            errors++;
            $display("FAIL rand_busy n%0d: busy=%h expected %h", n, busy, m_busy());
         end
         checks++;
         if (wb_valid !== m_wbv() || (m_wbv() && wb_dest !== m_wbd())) begin
            errors++;
            $display("FAIL rand_wb n%0d: wb_valid=%b wb_dest=%0d expected %b/%0d",
                     n, wb_valid, wb_dest, m_wbv(), m_wbd());
         end
         tick();
      end
   endtask

   initial begin
      issue_valid = 1'b0; issue_wr = 1'b0; issue_dest = 5'd0;
      src_a = 5'd0; src_b = 5'd0; flush = 1'b0;
      test_reset();
      test_raw_r5();
      test_r0_nowrite();
      test_dup();
      test_flush();
      test_stall_vs_issue();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
